// File: rtl/array_pair_host_pkg.sv
// Shared constants, state encoding and index helper for the array-pair host
// and the copy engine that talks to it.
package array_pair_host_pkg;

  // Array geometry and timeout budget.
  localparam int DEPTH = 10;
  localparam int DW    = 4;
  localparam int IW    = 4;
  localparam int TMO   = 63;

  // Width of the WAIT timer; it must be able to hold TMO itself.
  localparam int TW = $clog2(TMO + 1);

  // Highest legal element index; the engine uses the same constant.
  localparam logic [IW-1:0] IMAX = IW'(DEPTH - 1);

  // One-hot state encoding, legacy-compatible localparam form.
  localparam int SW = 5;
  typedef logic [SW-1:0] state_t;

  localparam state_t LOAD  = 5'b00001;
  localparam state_t RUN   = 5'b00010;
  localparam state_t WAIT  = 5'b00100;
  localparam state_t DRAIN = 5'b01000;
  localparam state_t ACKS  = 5'b10000;
  localparam state_t UNKN  = 5'bxxxxx;

  // True only for a known index inside 0..DEPTH-1. An unknown index makes
  // the comparison unknown, which callers treat as "not in range" by using
  // it as an if-condition.
  function automatic logic idx_ok(input logic [IW-1:0] idx);
    return (idx <= IMAX);
  endfunction

endpackage

// File: rtl/array_pair_host_if.sv
// Bundle of every non-clock signal between the host, the copy engine and
// the upstream/downstream streams.
//
// Handshakes: Load_Valid/Load_Ready and Out_Valid/Out_Ready transfer one
// element on every rising Clk edge where both are high; a valid source holds
// its data stable until that edge. Start and Ack are single-cycle pulses.
// Ns_of_J_Write is a one-cycle write strobe carrying Ms_of_I into N[J].
interface array_pair_host_if;
  import array_pair_host_pkg::*;

  logic          Load_Valid;
  logic [DW-1:0] Load_Data;
  logic          Load_Ready;
  logic          Start;
  logic          Ack;
  logic [IW-1:0] I;
  logic [DW-1:0] Ms_of_I;
  logic [IW-1:0] J;
  logic          Ns_of_J_Write;
  logic          Out_Valid;
  logic [DW-1:0] Out_Data;
  logic          Out_Ready;
  logic          Busy;
  logic          Err;
  state_t        State;

  // Host (responder) side.
  modport slave (
    input  Load_Valid, Load_Data, I, J, Ns_of_J_Write, Out_Ready,
    output Load_Ready, Start, Ack, Ms_of_I, Out_Valid, Out_Data, Busy, Err,
           State
  );

  // Engine plus stream side.
  modport master (
    output Load_Valid, Load_Data, I, J, Ns_of_J_Write, Out_Ready,
    input  Load_Ready, Start, Ack, Ms_of_I, Out_Valid, Out_Data, Busy, Err,
           State
  );

endinterface

// File: rtl/array_pair_host_array_bank.sv
// DEPTH x DW register file: one synchronous write port, one combinational
// read port. Out-of-range or unknown read indices return zero; out-of-range
// writes are dropped.
module array_bank
  import array_pair_host_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Wr_En,
  input  logic [IW-1:0] Wr_Idx,
  input  logic [DW-1:0] Wr_Data,
  input  logic [IW-1:0] Rd_Idx,
  output logic [DW-1:0] Rd_Data
);

  logic [DW-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, written only at legal indices.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (Wr_En && idx_ok(Wr_Idx)) begin
      mem_q[Wr_Idx] <= Wr_Data;
    end
  end

  // Read port: zero unless the index is known and in range.
  always_comb begin
    Rd_Data = '0;
    if (idx_ok(Rd_Idx)) begin
      Rd_Data = mem_q[Rd_Idx];
    end
  end

endmodule

// File: rtl/array_pair_host.sv
// Host side of the M-to-N array-copy engine. Loads M from an upstream
// stream, pulses Start, collects the engine's N[J] writes (with a timeout),
// streams N downstream and finally pulses Ack so the engine returns to idle.
module array_pair_host
  import array_pair_host_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  array_pair_host_if.slave bus
);

  state_t        state_q;
  state_t        state_nxt;
  logic [IW-1:0] ld_idx_q;
  logic [IW-1:0] rd_idx_q;
  logic [IW-1:0] wr_cnt_q;
  logic [TW-1:0] timer_q;
  logic          start_q;
  logic          ack_q;
  logic          err_q;

  logic          in_load;
  logic          in_run;
  logic          in_wait;
  logic          in_drain;
  logic          load_fire;
  logic          load_last;
  logic          out_fire;
  logic          drain_last;
  logic          j_ok;
  logic          wr_hit;
  logic          wr_bad;
  logic          wr_last;
  logic          tmo_hit;
  logic          m_we;
  logic          n_we;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] n_rd;

  assign in_load  = (state_q == LOAD);
  assign in_run   = (state_q == RUN);
  assign in_wait  = (state_q == WAIT);
  assign in_drain = (state_q == DRAIN);

  // Upstream load handshake; the element at IMAX closes the load phase.
  assign load_fire = in_load && bus.Load_Valid;
  assign load_last = load_fire && (ld_idx_q == IMAX);

  // Downstream drain handshake; the element at IMAX closes the drain phase.
  assign out_fire   = in_drain && bus.Out_Ready;
  assign drain_last = out_fire && (rd_idx_q == IMAX);

  // Engine writes: only legal indices during WAIT land in N. Anything else
  // (bad index, or a strobe in any other state) is flagged as an error.
  assign j_ok    = idx_ok(bus.J);
  assign wr_hit  = in_wait && bus.Ns_of_J_Write && j_ok;
  assign wr_bad  = bus.Ns_of_J_Write && !(in_wait && j_ok);
  assign wr_last = wr_hit && (wr_cnt_q == IW'(DEPTH - 1));

  // Timer reaches TMO on the edge that ends the TMO-th WAIT cycle.
  assign tmo_hit = in_wait && (timer_q == TW'(TMO - 1));

  assign m_we = load_fire;
  assign n_we = wr_hit;

  // Source array M: filled by the loader, read by the engine through I.
  array_bank u_m_bank (
    .Clk     (Clk),
    .Reset   (Reset),
    .Wr_En   (m_we),
    .Wr_Idx  (ld_idx_q),
    .Wr_Data (bus.Load_Data),
    .Rd_Idx  (bus.I),
    .Rd_Data (m_rd)
  );

  // Destination array N: written by the engine at J with M[I], read by the
  // drain stream at RdIdx.
  array_bank u_n_bank (
    .Clk     (Clk),
    .Reset   (Reset),
    .Wr_En   (n_we),
    .Wr_Idx  (bus.J),
    .Wr_Data (m_rd),
    .Rd_Idx  (rd_idx_q),
    .Rd_Data (n_rd)
  );

  // Next-state logic for the five-phase job sequence.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      LOAD:    if (load_last) state_nxt = RUN;
      RUN:     state_nxt = WAIT;
      WAIT:    if (wr_last || tmo_hit) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = ACKS;
      ACKS:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // State register plus registered Moore pulses for Start and Ack.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= LOAD;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      start_q <= (state_nxt == RUN);
      ack_q   <= (state_nxt == ACKS);
    end
  end

  // Load index: advances per accepted element, wraps to 0 after IMAX.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ld_idx_q <= '0;
    end else if (load_fire) begin
      ld_idx_q <= load_last ? '0 : ld_idx_q + 1'b1;
    end
  end

  // Drain index: advances per accepted output, wraps to 0 after IMAX.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_idx_q <= '0;
    end else if (out_fire) begin
      rd_idx_q <= drain_last ? '0 : rd_idx_q + 1'b1;
    end
  end

  // Write counter: cleared at job start, counts valid writes, saturates.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_cnt_q <= '0;
    end else if (in_run) begin
      wr_cnt_q <= '0;
    end else if (wr_hit && (wr_cnt_q != IW'(DEPTH))) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  // WAIT timer: cleared at job start, counts WAIT cycles, saturates at TMO.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      timer_q <= '0;
    end else if (in_run) begin
      timer_q <= '0;
    end else if (in_wait && (timer_q != TW'(TMO))) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Sticky error: set by stray/bad writes or timeout, cleared only in RUN.
  // A stray strobe during RUN itself still wins over the clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (wr_bad || tmo_hit) begin
      err_q <= 1'b1;
    end else if (in_run) begin
      err_q <= 1'b0;
    end
  end

  assign bus.Load_Ready = in_load;
  assign bus.Start      = start_q;
  assign bus.Ack        = ack_q;
  assign bus.Ms_of_I    = m_rd;
  assign bus.Out_Valid  = in_drain;
  assign bus.Out_Data   = n_rd;
  assign bus.Busy       = !in_load;
  assign bus.Err        = err_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_array_pair_host.sv
// Directed bench for array_pair_host: emulates the copy engine (high
// elements first, then low ones, each group in index order) and the
// upstream/downstream streams, and checks against hand-computed values.
module tb_array_pair_host;
  import array_pair_host_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  array_pair_host_if bus ();

  array_pair_host dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock and watchdog.
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] m_vals [DEPTH];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Element 0 is the most significant nibble.
  task automatic set_m(input logic [DW*DEPTH-1:0] v);
    for (int k = 0; k < DEPTH; k++) m_vals[k] = v[DW*DEPTH-1-DW*k -: DW];
  endtask

  task automatic load_exp(input logic [DW*DEPTH-1:0] v);
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(v[DW*DEPTH-1-DW*k -: DW]);
  endtask

  // Loader: ten back-to-back elements, then Start/RUN/WAIT checks.
  task automatic do_load();
    chk("load_ready", 32'(bus.Load_Ready), 1);
    for (int k = 0; k < DEPTH; k++) begin
      bus.Load_Valid = 1'b1;
      bus.Load_Data  = m_vals[k];
      step();
    end
    bus.Load_Valid = 1'b0;
    chk("start_pulse", 32'(bus.Start), 1);
    chk("state_run", 32'(bus.State), 32'(RUN));
    chk("busy_run", 32'(bus.Busy), 1);
    step();
    chk("start_single", 32'(bus.Start), 0);
    chk("state_wait", 32'(bus.State), 32'(WAIT));
  endtask

  // Engine emulation: n_wr writes, optional J=12 write before write bad_at.
  task automatic run_engine(input int n_wr, input int bad_at);
    int ord [DEPTH];
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_vals[i] >= 4'd8) begin ord[n] = i; n++; end
    for (int i = 0; i < DEPTH; i++) if (m_vals[i] <  4'd8) begin ord[n] = i; n++; end
    for (int k = 0; k < n_wr; k++) begin
      if (k == bad_at) begin
        bus.I = '0;
        bus.J = 4'd12;
        bus.Ns_of_J_Write = 1'b1;
        step();
        chk("err_after_bad", 32'(bus.Err), 1);
        chk("wait_after_bad", 32'(bus.State), 32'(WAIT));
      end
      bus.I = IW'(ord[k]);
      bus.J = IW'(k);
      bus.Ns_of_J_Write = 1'b1;
      #1;
      chk("ms_of_i", 32'(bus.Ms_of_I), 32'(m_vals[ord[k]]));
      step();
    end
    bus.Ns_of_J_Write = 1'b0;
  endtask

  // Drain against exp_q; mode 1 drives Out_Ready as 1,0,0,1,0,0,...
  task automatic do_drain(input int mode);
    int            got;
    int            cyc;
    logic          rdy;
    logic          stalled;
    logic [DW-1:0] held;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (got < DEPTH && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      bus.Out_Ready = rdy;
      chk("out_valid", 32'(bus.Out_Valid), 1);
      chk($sformatf("out_data[%0d]", got), 32'(bus.Out_Data), 32'(exp_q[0]));
      if (stalled) chk("out_hold", 32'(bus.Out_Data), 32'(held));
      held = bus.Out_Data;
      stalled = !rdy;
      if (rdy) begin
        void'(exp_q.pop_front());
        got++;
      end
      step();
      cyc++;
    end
    bus.Out_Ready = 1'b0;
    chk("drain_count", 32'(got), DEPTH);
    chk("ack_pulse", 32'(bus.Ack), 1);
    chk("state_acks", 32'(bus.State), 32'(ACKS));
    chk("out_valid_off", 32'(bus.Out_Valid), 0);
    step();
    chk("ack_single", 32'(bus.Ack), 0);
    chk("state_load", 32'(bus.State), 32'(LOAD));
    chk("busy_load", 32'(bus.Busy), 0);
  endtask

  initial begin
    int cyc;
    Reset = 1'b1;
    bus.Load_Valid = 1'b0;
    bus.Load_Data = '0;
    bus.I = 4'd3;
    bus.J = '0;
    bus.Ns_of_J_Write = 1'b0;
    bus.Out_Ready = 1'b0;
    step();
    step();

    // Reset state.
    chk("rst_state", 32'(bus.State), 32'(LOAD));
    chk("rst_start", 32'(bus.Start), 0);
    chk("rst_ack", 32'(bus.Ack), 0);
    chk("rst_out_valid", 32'(bus.Out_Valid), 0);
    chk("rst_err", 32'(bus.Err), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_load_ready", 32'(bus.Load_Ready), 1);
    chk("rst_ms_of_i", 32'(bus.Ms_of_I), 0);
    chk("rst_out_data", 32'(bus.Out_Data), 0);
    Reset = 1'b0;
    step();

    // Nominal job.
    set_m(40'h135789BCEF);
    load_exp(40'h89BCEF1357);
    do_load();
    bus.I = 4'd9;
    #1;
    chk("ms_of_i_9", 32'(bus.Ms_of_I), 32'hF);
    bus.I = 4'd12;
    #1;
    chk("ms_of_i_12", 32'(bus.Ms_of_I), 0);
    run_engine(DEPTH, -1);
    chk("nom_drain_state", 32'(bus.State), 32'(DRAIN));
    chk("nom_out_valid", 32'(bus.Out_Valid), 1);
    do_drain(0);
    chk("nom_err", 32'(bus.Err), 0);

    // All-low chunk: copy keeps the order.
    set_m(40'h0123456777);
    load_exp(40'h0123456777);
    do_load();
    run_engine(DEPTH, -1);
    chk("low_drain_state", 32'(bus.State), 32'(DRAIN));
    do_drain(0);
    chk("low_err", 32'(bus.Err), 0);

    // Bad index once, before the last write.
    set_m(40'h135789BCEF);
    load_exp(40'h89BCEF1357);
    do_load();
    run_engine(DEPTH, DEPTH - 1);
    chk("bad_drain_state", 32'(bus.State), 32'(DRAIN));
    chk("bad_err_drain", 32'(bus.Err), 1);
    do_drain(0);
    chk("bad_err_load", 32'(bus.Err), 1);

    // Backpressure job; Err cleared by RUN.
    set_m(40'h2468ACE135);
    load_exp(40'h8ACE246135);
    do_load();
    chk("err_cleared", 32'(bus.Err), 0);
    run_engine(DEPTH, -1);
    do_drain(1);
    chk("bp_err", 32'(bus.Err), 0);

    // Reset in mid-WAIT after five writes.
    set_m(40'h135789BCEF);
    do_load();
    run_engine(5, -1);
    chk("mid_state_wait", 32'(bus.State), 32'(WAIT));
    bus.I = '0;
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_state", 32'(bus.State), 32'(LOAD));
    chk("mid_rst_start", 32'(bus.Start), 0);
    chk("mid_rst_ack", 32'(bus.Ack), 0);
    chk("mid_rst_out_valid", 32'(bus.Out_Valid), 0);
    chk("mid_rst_err", 32'(bus.Err), 0);
    chk("mid_rst_busy", 32'(bus.Busy), 0);
    chk("mid_rst_ms_of_i", 32'(bus.Ms_of_I), 0);
    chk("mid_rst_out_data", 32'(bus.Out_Data), 0);
    step();
    Reset = 1'b0;
    step();

    // Timeout after four writes; N was cleared by the reset above.
    load_exp(40'h89BC000000);
    do_load();
    run_engine(4, -1);
    cyc = 4;
    while (bus.State == WAIT && cyc < 200) begin
      if (cyc == TMO - 1) chk("err_pre_tmo", 32'(bus.Err), 0);
      step();
      cyc++;
    end
    chk("tmo_wait_cycles", 32'(cyc), TMO);
    chk("tmo_err", 32'(bus.Err), 1);
    chk("tmo_state", 32'(bus.State), 32'(DRAIN));
    do_drain(0);
    chk("tmo_err_load", 32'(bus.Err), 1);

    // A fresh full job after all of the above.
    set_m(40'h135789BCEF);
    load_exp(40'h89BCEF1357);
    do_load();
    chk("final_err_cleared", 32'(bus.Err), 0);
    run_engine(DEPTH, -1);
    do_drain(0);
    chk("final_err", 32'(bus.Err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
